seg7_scan_reader: RTL and testbench



---
 rtl/seg7_scan_reader_if.sv | 23 ++
 rtl/seg7_scan_reader.sv | 181 ++++++++++++++++++
 tb/tb_seg7_scan_reader.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_reader_if.sv
// -----------------------------------------------------------------------------
// seg7_scan_reader_if
// Bundles the multiplexed 7-segment display bus (inputs to the reader) with the
// recovered word (outputs of the reader).
//   iAn    : per-digit anode enables, active-low, NDIG bits
//   iS     : shared segment bus abcdefg, active-low
//   oD     : recovered word, digit k in oD[4k+3:4k]
//   oErr   : per-digit illegal-glyph flags
//   oValid : one-cycle strobe, oD/oErr updated this cycle
// master = display side / bench, slave = seg7_scan_reader.
// -----------------------------------------------------------------------------
interface seg7_scan_reader_if #(
   parameter int NDIG = 4
);
   logic [NDIG-1:0]   iAn;
   logic [6:0]        iS;
   logic [4*NDIG-1:0] oD;
   logic [NDIG-1:0]   oErr;
   logic              oValid;

   modport master (output iAn, output iS, input oD, input oErr, input oValid);
   modport slave  (input iAn, input iS, output oD, output oErr, output oValid);
endinterface

// File: rtl/seg7_scan_reader.sv
// -----------------------------------------------------------------------------
// seg7_scan_reader
// Inverse of a hex-to-7-segment decoder on a multiplexed, active-low display.
// Synchronizes the anode and segment lines, waits for STABLE identical samples
// of a single selected digit, decodes the glyph back to a nibble and collects
// one capture per digit into a shadow word. When every digit has been captured
// the shadow word is published on oD/oErr with a one-cycle oValid strobe.
// Ports:
//   iclk   : system clock
//   irst_n : asynchronous active-low reset
//   bus    : seg7_scan_reader_if.slave (iAn, iS in; oD, oErr, oValid out)
// -----------------------------------------------------------------------------
module seg7_scan_reader #(
   parameter int NDIG   = 4,
   parameter int STABLE = 3
) (
   input  logic                 iclk,
   input  logic                 irst_n,
   seg7_scan_reader_if.slave    bus
);

   localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int CW = $clog2(STABLE);
   localparam logic [CW-1:0]   CNT_TOP = CW'(STABLE - 1);
   localparam logic [NDIG-1:0] ONE_N   = NDIG'(1);

   // Glyph lookup: returns {err, nibble}; illegal patterns give nibble 0.
   function automatic logic [4:0] decode_glyph(input logic [6:0] pat);
      logic [4:0] res;
      case (pat)
         7'b0000001: res = {1'b0, 4'h0};
         7'b1001111: res = {1'b0, 4'h1};
         7'b0010010: res = {1'b0, 4'h2};
         7'b0000110: res = {1'b0, 4'h3};
         7'b1001100: res = {1'b0, 4'h4};
         7'b0100100: res = {1'b0, 4'h5};
         7'b0100000: res = {1'b0, 4'h6};
         7'b0001111: res = {1'b0, 4'h7};
         7'b0000000: res = {1'b0, 4'h8};
         7'b0001100: res = {1'b0, 4'h9};
         7'b0000100: res = {1'b0, 4'h9};
         7'b0001000: res = {1'b0, 4'hA};
         7'b1100000: res = {1'b0, 4'hB};
         7'b0110001: res = {1'b0, 4'hC};
         7'b1000010: res = {1'b0, 4'hD};
         7'b0110000: res = {1'b0, 4'hE};
         7'b0111000: res = {1'b0, 4'hF};
         default:    res = {1'b1, 4'h0};
      endcase
      return res;
   endfunction

   logic [NDIG-1:0]   an_meta_r;
   logic [NDIG-1:0]   an_sync_r;
   logic [6:0]        seg_meta_r;
   logic [6:0]        seg_sync_r;
   logic              prev_ok_r;
   logic [IW-1:0]     prev_idx_r;
   logic [6:0]        prev_pat_r;
   logic [CW-1:0]     cnt_r;
   logic [NDIG-1:0]   mask_r;
   logic [4*NDIG-1:0] shadow_nib_r;
   logic [NDIG-1:0]   shadow_err_r;
   logic [4*NDIG-1:0] d_r;
   logic [NDIG-1:0]   err_r;
   logic              valid_r;

   logic [NDIG-1:0]   low_s;
   logic              usable_s;
   logic [IW-1:0]     idx_s;
   logic [CW-1:0]     cnt_next_s;
   logic              capture_s;
   logic [4:0]        glyph_s;
   logic [NDIG-1:0]   cap_bit_s;

   // A sample is usable only when exactly one anode is low (one-hot test on ~iAn).
   assign low_s    = ~an_sync_r;
   assign usable_s = (low_s != '0) && ((low_s & (low_s - ONE_N)) == '0);
   assign glyph_s  = decode_glyph(seg_sync_r);

   // Index of the low anode; OR-reduction is exact because only one-hot samples are used.
   always_comb begin
      idx_s = '0;
      for (int i = 0; i < NDIG; i++) begin
         idx_s = idx_s | (low_s[i] ? IW'(i) : '0);
      end
   end

   // Stability count and capture detect; capture fires only on the step into CNT_TOP.
   always_comb begin
      cnt_next_s = '0;
      if (!usable_s) begin
         cnt_next_s = '0;
      end else if (prev_ok_r && (idx_s == prev_idx_r) && (seg_sync_r == prev_pat_r)) begin
         if (cnt_r == CNT_TOP) begin
            cnt_next_s = cnt_r;
         end else begin
            cnt_next_s = cnt_r + CW'(1);
         end
      end else begin
         cnt_next_s = '0;
      end
      capture_s = (cnt_next_s == CNT_TOP) && (cnt_r != CNT_TOP);
   end

   assign cap_bit_s = capture_s ? (ONE_N << idx_s) : '0;

   // Two-flop synchronizers for the asynchronous display lines.
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         an_meta_r  <= '0;
         an_sync_r  <= '0;
         seg_meta_r <= 7'b0000000;
         seg_sync_r <= 7'b0000000;
      end else begin
         an_meta_r  <= bus.iAn;
         an_sync_r  <= an_meta_r;
         seg_meta_r <= bus.iS;
         seg_sync_r <= seg_meta_r;
      end
   end

   // Previous-sample register and stability counter.
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         prev_ok_r  <= 1'b0;
         prev_idx_r <= '0;
         prev_pat_r <= 7'b0000000;
         cnt_r      <= '0;
      end else begin
         prev_ok_r  <= usable_s;
         prev_idx_r <= idx_s;
         prev_pat_r <= seg_sync_r;
         cnt_r      <= cnt_next_s;
      end
   end

   // Shadow word: a capture overwrites only the selected digit's slot.
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         shadow_nib_r <= '0;
         shadow_err_r <= '0;
      end else begin
         for (int k = 0; k < NDIG; k++) begin
            if (cap_bit_s[k]) begin
               shadow_nib_r[4*k +: 4] <= glyph_s[3:0];
               shadow_err_r[k]        <= glyph_s[4];
            end else begin
               shadow_nib_r[4*k +: 4] <= shadow_nib_r[4*k +: 4];
               shadow_err_r[k]        <= shadow_err_r[k];
            end
         end
      end
   end

   // Frame completion: publish the shadow word one edge after the mask fills;
   // a capture on that same edge seeds the freshly cleared mask.
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         mask_r  <= '0;
         d_r     <= '0;
         err_r   <= '0;
         valid_r <= 1'b0;
      end else if (&mask_r) begin
         mask_r  <= cap_bit_s;
         d_r     <= shadow_nib_r;
         err_r   <= shadow_err_r;
         valid_r <= 1'b1;
      end else begin
         mask_r  <= mask_r | cap_bit_s;
         d_r     <= d_r;
         err_r   <= err_r;
         valid_r <= 1'b0;
      end
   end

   assign bus.oD     = d_r;
   assign bus.oErr   = err_r;
   assign bus.oValid = valid_r;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_reader
// Drives scan sequences onto the display bus and compares every cycle against a
// run-length reference model built from the glyph table; directed scenarios add
// fixed expected words.
// -----------------------------------------------------------------------------
module tb_seg7_scan_reader;

   localparam int NDIG   = 4;
   localparam int STABLE = 3;

   logic iclk   = 1'b0;
   logic irst_n = 1'b0;

   seg7_scan_reader_if #(.NDIG(NDIG)) bus ();

   seg7_scan_reader #(.NDIG(NDIG), .STABLE(STABLE)) dut (
      .iclk   (iclk),
      .irst_n (irst_n),
      .bus    (bus)
   );

   always #5 iclk = ~iclk;

   localparam logic [6:0] GLYPH_PAT [17] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
      7'b0100000, 7'b0001111, 7'b0000000, 7'b0001100, 7'b0000100, 7'b0001000,
      7'b1100000, 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
   localparam logic [3:0] GLYPH_VAL [17] = '{
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'h9, 4'hA,
      4'hB, 4'hC, 4'hD, 4'hE, 4'hF};

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int valid_cnt   = 0;
   int last_valid  = -10;

   // reference model state
   logic [3:0]  m_s1_an, m_s2_an;
   logic [6:0]  m_s1_s, m_s2_s;
   bit          m_prev_ok;
   int          m_prev_idx;
   logic [6:0]  m_prev_pat;
   int          m_run;
   bit          m_cap [NDIG];
   logic [3:0]  m_nib [NDIG];
   bit          m_er  [NDIG];
   logic [15:0] m_d;
   logic [3:0]  m_err;
   bit          m_valid;

   function automatic logic [4:0] ref_decode(input logic [6:0] p);
      for (int i = 0; i < 17; i++) begin
         if (p == GLYPH_PAT[i]) return {1'b0, GLYPH_VAL[i]};
      end
      return 5'b10000;
   endfunction

   task automatic model_reset();
      m_s1_an = 4'h0; m_s2_an = 4'h0; m_s1_s = 7'h00; m_s2_s = 7'h00;
      m_prev_ok = 1'b0; m_prev_idx = 0; m_prev_pat = 7'h00; m_run = 0;
      for (int k = 0; k < NDIG; k++) begin
         m_cap[k] = 1'b0; m_nib[k] = 4'h0; m_er[k] = 1'b0;
      end
      m_d = 16'h0000; m_err = 4'h0; m_valid = 1'b0;
   endtask

   // One clock edge of the model: the sample seen now is the input from two edges ago.
   task automatic model_edge(input logic [3:0] an, input logic [6:0] s);
      int zeros = 0;
      int idx = 0;
      bit ok, cap, full;
      logic [4:0] g;
      for (int k = 0; k < NDIG; k++) begin
         if (m_s2_an[k] == 1'b0) begin zeros++; idx = k; end
      end
      ok = (zeros == 1);
      if (!ok) m_run = 0;
      else if (m_prev_ok && idx == m_prev_idx && m_s2_s == m_prev_pat) m_run++;
      else m_run = 1;
      cap = ok && (m_run == STABLE);
      m_prev_ok = ok; m_prev_idx = idx; m_prev_pat = m_s2_s;
      full = 1'b1;
      for (int k = 0; k < NDIG; k++) full = full & m_cap[k];
      if (full) begin
         for (int k = 0; k < NDIG; k++) begin
            m_d[4*k +: 4] = m_nib[k]; m_err[k] = m_er[k]; m_cap[k] = 1'b0;
         end
         m_valid = 1'b1;
      end else begin
         m_valid = 1'b0;
      end
      if (cap) begin
         g = ref_decode(m_s2_s);
         m_nib[idx] = g[3:0]; m_er[idx] = g[4]; m_cap[idx] = 1'b1;
      end
      m_s2_an = m_s1_an; m_s2_s = m_s1_s;
      m_s1_an = an;      m_s1_s = s;
   endtask

   task automatic step(input logic [3:0] an, input logic [6:0] s, input bit rst);
      @(negedge iclk);
      bus.iAn = an;
      bus.iS  = s;
      irst_n  = rst ? 1'b0 : 1'b1;
      if (rst) model_reset();
      else     model_edge(an, s);
      @(posedge iclk);
      #1;
      cyc++;
      vectors++;
      if (bus.oValid !== m_valid || bus.oD !== m_d || bus.oErr !== m_err) begin
         miscompares++;
         $display("FAIL cycle_model @%0d: got valid=%b d=%h err=%b, expected valid=%b d=%h err=%b",
                  cyc, bus.oValid, bus.oD, bus.oErr, m_valid, m_d, m_err);
      end
      if (bus.oValid === 1'b1) begin
         vectors++;
         if (last_valid == cyc - 1) begin
            miscompares++;
            $display("FAIL back_to_back_strobe @%0d: got strobes at %0d and %0d, expected gap", cyc, last_valid, cyc);
         end
         last_valid = cyc;
         valid_cnt++;
      end
   endtask

   task automatic dwell(input int k, input logic [6:0] s, input int n);
      repeat (n) step(~(4'b0001 << k), s, 1'b0);
   endtask

   task automatic idle(input int n);
      repeat (n) step(4'b1111, 7'h7F, 1'b0);
   endtask

   task automatic check_frame(input string name, input int strobes_before,
                              input logic [15:0] exp_d, input logic [3:0] exp_err);
      vectors++;
      if (valid_cnt - strobes_before != 1) begin
         miscompares++;
         $display("FAIL %s_strobes: got %0d, expected 1", name, valid_cnt - strobes_before);
      end
      vectors++;
      if (bus.oD !== exp_d || bus.oErr !== exp_err) begin
         miscompares++;
         $display("FAIL %s_word: got d=%h err=%b, expected d=%h err=%b", name, bus.oD, bus.oErr, exp_d, exp_err);
      end
   endtask

   task automatic test_reset();
      int v0;
      repeat (6) step(4'($urandom), 7'($urandom), 1'b1);
      vectors++;
      if (bus.oD !== 16'h0000 || bus.oErr !== 4'h0 || bus.oValid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_values: got d=%h err=%b valid=%b, expected 0/0/0", bus.oD, bus.oErr, bus.oValid);
      end
      idle(3);
      v0 = valid_cnt;
      dwell(0, 7'b0000001, 8); dwell(1, 7'b1001111, 8); dwell(2, 7'b0010010, 8);
      idle(4);
      vectors++;
      if (valid_cnt != v0) begin
         miscompares++;
         $display("FAIL reset_no_early_strobe: got %0d strobes, expected 0", valid_cnt - v0);
      end
      step(4'b1111, 7'h7F, 1'b1);
      idle(3);
   endtask

   task automatic test_normal();
      int v0, start;
      v0 = valid_cnt;
      dwell(0, 7'b1001111, 8); dwell(1, 7'b0010010, 8); dwell(2, 7'b0000110, 8);
      start = cyc;
      dwell(3, 7'b1001100, 8);
      idle(4);
      check_frame("normal", v0, 16'h4321, 4'b0000);
      vectors++;
      if (last_valid != start + 2 + STABLE + 1) begin
         miscompares++;
         $display("FAIL normal_latency: got strobe at %0d, expected %0d", last_valid, start + 2 + STABLE + 1);
      end
   endtask

   task automatic test_glitch();
      int v0;
      v0 = valid_cnt;
      dwell(0, 7'b0100100, 8);
      dwell(1, 7'b0010010, 2);
      dwell(1, 7'b0000110, 8);
      dwell(2, 7'b0000100, 8); dwell(3, 7'b0000001, 8);
      idle(4);
      check_frame("glitch", v0, 16'h0935, 4'b0000);
   endtask

   task automatic test_invalid();
      int v0;
      v0 = valid_cnt;
      dwell(0, 7'b1100000, 8); dwell(1, 7'b0001111, 8);
      dwell(2, 7'b1111111, 8); dwell(3, 7'b0000000, 8);
      idle(4);
      check_frame("invalid", v0, 16'h807B, 4'b0100);
   endtask

   task automatic test_bad_select();
      int v0;
      v0 = valid_cnt;
      dwell(0, 7'b0110001, 8); dwell(1, 7'b1000010, 8);
      repeat (10) step(4'b0011, 7'b0000000, 1'b0);
      repeat (10) step(4'b1111, 7'b0000000, 1'b0);
      vectors++;
      if (valid_cnt != v0) begin
         miscompares++;
         $display("FAIL bad_select_strobe: got %0d strobes, expected 0", valid_cnt - v0);
      end
      dwell(2, 7'b0110000, 8); dwell(3, 7'b0111000, 8);
      idle(4);
      check_frame("bad_select", v0, 16'hFEDC, 4'b0000);
   endtask

   task automatic test_reset_mid_frame();
      int v0;
      dwell(0, 7'b1001111, 8); dwell(1, 7'b0010010, 8);
      step(4'b1111, 7'h7F, 1'b1);
      v0 = valid_cnt;
      dwell(2, 7'b0100000, 8); dwell(3, 7'b0001111, 8);
      idle(4);
      vectors++;
      if (valid_cnt != v0 || bus.oD !== 16'h0000) begin
         miscompares++;
         $display("FAIL reset_mid_frame_discard: got %0d strobes d=%h, expected 0 strobes d=0000",
                  valid_cnt - v0, bus.oD);
      end
      dwell(0, 7'b0001100, 8); dwell(1, 7'b0001000, 8);
      dwell(2, 7'b0100000, 8); dwell(3, 7'b0001111, 8);
      idle(4);
      check_frame("reset_mid_frame", v0, 16'h76A9, 4'b0000);
   endtask

   task automatic test_random();
      int k, n;
      logic [3:0] an;
      logic [6:0] s;
      for (int d = 0; d < 250; d++) begin
         k  = $urandom_range(NDIG - 1);
         an = ($urandom_range(9) == 0) ? 4'($urandom) : ~(4'b0001 << k);
         s  = ($urandom_range(4) == 0) ? 7'($urandom) : GLYPH_PAT[$urandom_range(16)];
         n  = $urandom_range(8, 1);
         if ($urandom_range(79) == 0) step(an, s, 1'b1);
         repeat (n) step(an, s, 1'b0);
      end
      idle(6);
   endtask

   initial begin
      bus.iAn = 4'b1111;
      bus.iS  = 7'h7F;
      model_reset();
      test_reset();
      test_normal();
      test_glitch();
      test_invalid();
      test_bad_select();
      test_reset_mid_frame();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
